// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer. It owns the PC register and drives instruction memory.
// The next PC is chosen from sequential (+PC_STEP), branch redirect, hold (stall or miss)
// and halt. The block tracks an outstanding imem access and generates the IF/ID
// write-enable and flush.
// Ports:
//   clk, rst_n         clock; synchronous active-low reset
//   stall              hazard-unit stall: hold PC, no IF/ID write
//   halt_id            HLT decoded in ID this cycle
//   br_taken/br_target branch resolved taken in ID, with its redirect target
//   imem_ready         imem returns the instruction for imem_addr this cycle
//   imem_req/imem_addr fetch request and address (address = pc)
//   pc, pc_inc         registered fetch PC, and pc + PC_STEP (16-bit wrap)
//   if_valid, flush_if IF/ID write enable and squash
//   halted             fetch permanently stopped (registered)
//   stall_cycles       saturating count of non-advancing fetch cycles
module fetch_ctrl #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] PC_STEP  = 16'h0002
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        halt_id,
   input  logic        br_taken,
   input  logic [15:0] br_target,
   input  logic        imem_ready,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   output logic [15:0] pc,
   output logic [15:0] pc_inc,
   output logic        if_valid,
   output logic        flush_if,
   output logic        halted,
   output logic [15:0] stall_cycles
);

   localparam logic [15:0] SatMax = 16'hFFFF;

   typedef enum logic [1:0] {FETCH, MISS, DRAIN, HALTED} fetchStateT;

   fetchStateT  state, stateNext;
   logic [15:0] pcNext;
   logic [15:0] pendTgt, pendTgtNext;
   logic        pendHalt, pendHaltNext;

   assign imem_addr = pc;
   assign pc_inc    = pc + PC_STEP;

   // Next-state, next-PC and IF/ID control.
   always_comb begin
      stateNext    = state;
      pcNext       = pc;
      pendTgtNext  = pendTgt;
      pendHaltNext = pendHalt;
      imem_req     = 1'b0;
      if_valid     = 1'b0;
      flush_if     = 1'b0;

      case (state)
         FETCH, MISS: begin
            imem_req = 1'b1;
            if (halt_id) begin
               // A miss in progress means imem is still busy, so wait for it in DRAIN.
               flush_if = 1'b1;
               if (state == FETCH && imem_ready) begin
                  stateNext = HALTED;
               end else begin
                  stateNext    = DRAIN;
                  pendHaltNext = 1'b1;
               end
            end else if (br_taken) begin
               flush_if = 1'b1;
               if (state == FETCH && imem_ready) begin
                  pcNext = br_target;
               end else begin
                  stateNext   = DRAIN;
                  pendTgtNext = br_target;
               end
            end else if (stall) begin
               // The returned word is dropped; the same pc is requested again from FETCH.
               if (state == MISS && imem_ready) begin
                  stateNext = FETCH;
               end
            end else if (imem_ready) begin
               if_valid  = 1'b1;
               pcNext    = pc_inc;
               stateNext = FETCH;
            end else begin
               stateNext = MISS;
            end
         end

         DRAIN: begin
            // Wait for the outstanding access; its data is discarded.
            imem_req = 1'b1;
            if (halt_id) begin
               flush_if     = 1'b1;
               pendHaltNext = 1'b1;
            end else if (br_taken) begin
               flush_if    = 1'b1;
               pendTgtNext = br_target;
            end
            if (imem_ready) begin
               if (pendHaltNext) begin
                  stateNext = HALTED;
               end else begin
                  pcNext    = pendTgtNext;
                  stateNext = FETCH;
               end
            end
         end

         HALTED: begin
            stateNext = HALTED;
         end

         default: begin
            stateNext = FETCH;
         end
      endcase

      if (!rst_n) begin
         imem_req = 1'b0;
         if_valid = 1'b0;
         flush_if = 1'b0;
      end
   end

   // State, PC, pending-redirect and statistics registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= FETCH;
         pc           <= RESET_PC;
         pendTgt      <= 16'h0000;
         pendHalt     <= 1'b0;
         halted       <= 1'b0;
         stall_cycles <= 16'h0000;
      end else begin
         state    <= stateNext;
         pc       <= pcNext;
         pendTgt  <= pendTgtNext;
         pendHalt <= pendHaltNext;
         halted   <= (stateNext == HALTED);
         // Every live cycle that does not accept an instruction is a stall cycle.
         if (state != HALTED && !if_valid && stall_cycles != SatMax) begin
            stall_cycles <= stall_cycles + 16'(1);
         end
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl. Each accepted fetch is predicted
// into a queue when its stimulus is driven. The queue is then drained by a monitor
// that watches if_valid.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, halt_id, br_taken, imem_ready;
   logic [15:0] br_target;
   logic        imem_req, if_valid, flush_if, halted;
   logic [15:0] imem_addr, pc, pc_inc, stall_cycles;

   int          nTests = 0;
   int          nFail  = 0;
   logic [15:0] expQ[$];

   always #5 clk = ~clk;

   fetch_ctrl #(.RESET_PC(16'h0000), .PC_STEP(16'h0002)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .halt_id(halt_id),
      .br_taken(br_taken), .br_target(br_target), .imem_ready(imem_ready),
      .imem_req(imem_req), .imem_addr(imem_addr), .pc(pc), .pc_inc(pc_inc),
      .if_valid(if_valid), .flush_if(flush_if), .halted(halted),
      .stall_cycles(stall_cycles)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input logic rdy, input logic stl, input logic hlt,
                        input logic br, input logic [15:0] tgt);
      imem_ready = rdy;
      stall      = stl;
      halt_id    = hlt;
      br_taken   = br;
      br_target  = tgt;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // A clean fetch at the expected address: predict it, then advance one cycle.
   task automatic fetchOk(input logic [15:0] addr);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      check("ifValid", 16'(if_valid), 16'h0001);
      expQ.push_back(addr);
      tick();
   endtask

   // Scoreboard monitor: every accepted fetch must match the oldest prediction.
   always @(negedge clk) begin
      if (rst_n && if_valid) begin
         if (expQ.size() == 0) check("spuriousFetch", 16'(if_valid), 16'h0000);
         else                  check("fetchAddr", imem_addr, expQ.pop_front());
      end
   end

   initial begin
      rst_n = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      check("rstImemReq", 16'(imem_req), 16'h0000);
      check("rstIfValid", 16'(if_valid), 16'h0000);
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      check("rstPc", pc, 16'h0000);
      check("rstHalted", 16'(halted), 16'h0000);
      check("rstStallCnt", stall_cycles, 16'h0000);

      // Sequential fetch from reset
      for (int i = 0; i < 4; i++) begin
         check("seqPc", pc, 16'(2 * i));
         fetchOk(16'(2 * i));
      end
      check("seqPc4", pc, 16'h0008);
      check("seqStallCnt", stall_cycles, 16'h0000);
      for (int i = 4; i < 8; i++) fetchOk(16'(2 * i));

      // Three-cycle miss at 0010
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      check("missIfValid", 16'(if_valid), 16'h0000);
      check("missAddr0", imem_addr, 16'h0010);
      tick();
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
         check("missAddrHeld", imem_addr, 16'h0010);
         check("missReq", 16'(imem_req), 16'h0001);
         tick();
      end
      fetchOk(16'h0010);
      check("missPcAfter", pc, 16'h0012);
      check("missStallCnt", stall_cycles, 16'h0003);

      // Branch during a miss: DRAIN, then redirect
      for (int a = 'h12; a <= 'h1E; a += 2) fetchOk(16'(a));
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      tick();
      check("brMissPc", pc, 16'h0020);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0100);
      check("brFlush", 16'(flush_if), 16'h0001);
      check("brIfValid", 16'(if_valid), 16'h0000);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      check("drainReq", 16'(imem_req), 16'h0001);
      check("drainIfValid", 16'(if_valid), 16'h0000);
      tick();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      check("drainDoneIfValid", 16'(if_valid), 16'h0000);
      tick();
      check("brTargetPc", pc, 16'h0100);
      fetchOk(16'h0100);
      check("brStallCnt", stall_cycles, 16'h0007);

      // Same-cycle halt and branch: halt wins
      drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0200);
      check("haltFlush", 16'(flush_if), 16'h0001);
      check("haltIfValid", 16'(if_valid), 16'h0000);
      tick();
      check("haltedFlag", 16'(halted), 16'h0001);
      check("haltPc", pc, 16'h0102);
      for (int i = 0; i < 3; i++) begin
         drive(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1, 16'h0300);
         check("haltReq", 16'(imem_req), 16'h0000);
         check("haltNoFlush", 16'(flush_if), 16'h0000);
         tick();
      end
      check("haltPcFrozen", pc, 16'h0102);
      check("haltStallFrozen", stall_cycles, 16'h0008);

      // PC wrap at FFFE, then stall hold
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      tick();
      rst_n = 1'b1;
      #1;
      check("rst2Halted", 16'(halted), 16'h0000);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFE);
      check("wrapBrFlush", 16'(flush_if), 16'h0001);
      tick();
      check("wrapPc", pc, 16'hFFFE);
      check("wrapPcInc", pc_inc, 16'h0000);
      fetchOk(16'hFFFE);
      check("wrapPcAfter", pc, 16'h0000);
      check("wrapPcIncAfter", pc_inc, 16'h0002);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0040);
      tick();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
         check("stallIfValid", 16'(if_valid), 16'h0000);
         check("stallAddr", imem_addr, 16'h0040);
         tick();
      end
      check("stallPc", pc, 16'h0040);
      check("stallCnt", stall_cycles, 16'h0004);
      fetchOk(16'h0040);

      // Reset in DRAIN drops the pending target
      drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0300);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      check("rstDrainReq", 16'(imem_req), 16'h0001);
      tick();
      rst_n = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      check("rst3Req", 16'(imem_req), 16'h0000);
      check("rst3IfValid", 16'(if_valid), 16'h0000);
      check("rst3Flush", 16'(flush_if), 16'h0000);
      tick();
      rst_n = 1'b1;
      #1;
      check("rst3Pc", pc, 16'h0000);
      check("rst3StallCnt", stall_cycles, 16'h0000);
      fetchOk(16'h0000);
      check("rst3PcNext", pc, 16'h0002);
      fetchOk(16'h0002);
      check("rst3PcNext2", pc, 16'h0004);

      check("scoreboardEmpty", 16'(expQ.size()), 16'h0000);
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
